// File: rtl/if_fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch stage.
// Fetch FSM encoding and the entry format buffered between IF and IF/ID.
package if_fetch_unit_pkg;

    localparam logic [31:0] NOP_INST         = 32'h0000_0000;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef enum logic [1:0] {
        S_REQ,
        S_WAIT,
        S_DROP
    } fetch_state_e;

    typedef struct packed {
        logic [31:0] pcAdd4;
        logic [31:0] inst;
    } fetch_entry_t;

endpackage

// File: rtl/if_fetch_unit_fetch_buffer.sv
// Two-entry instruction FIFO: written one cycle after a push, head visible combinationally.
// No internal backpressure; the caller never pushes when full. Clear wins over push and pop.
module if_fetch_unit_fetch_buffer
    import if_fetch_unit_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    input  logic         push_i,
    input  fetch_entry_t push_dat_i,
    input  logic         pop_i,
    input  logic         clear_i,
    output fetch_entry_t head_o,
    output logic [1:0]   count_o
);

    fetch_entry_t mem_q [2];
    logic         head_q, head_d;
    logic         tail_q, tail_d;
    logic [1:0]   count_q, count_d;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (clear_i) begin
            head_d  = 1'b0;
            tail_d  = 1'b0;
            count_d = 2'd0;
        end else begin
            if (push_i) tail_d = ~tail_q;
            if (pop_i)  head_d = ~head_q;
            case ({push_i, pop_i})
                2'b10:   count_d = count_q + 2'd1;
                2'b01:   count_d = count_q - 2'd1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head_q  <= 1'b0;
            tail_q  <= 1'b0;
            count_q <= 2'd0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            if (push_i && !clear_i) mem_q[tail_q] <= push_dat_i;
        end
    end

    assign head_o  = mem_q[head_q];
    assign count_o = count_q;

endmodule

// File: rtl/if_fetch_unit.sv
// Fetch stage: owns the PC, keeps one imem fetch in flight, presents the FIFO head to IF/ID.
// Best case accept->IF_valid is 2 cycles; requests stop while the buffer is full or on flush.
module if_fetch_unit
    import if_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        IFID_Write,
    input  logic        IF_Flush,
    input  logic [31:0] branch_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_valid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pcAdd4_IF,
    output logic [31:0] inst_IF,
    output logic        IF_valid
);

    if (FIFO_DEPTH != 2) begin : g_bad_depth
        $error("if_fetch_unit: FIFO_DEPTH must be 2");
    end

    fetch_state_e state_q;
    logic [31:0]  pc_q;
    logic [31:0]  fetch_pcadd4_q;
    logic         rst_q;

    logic         accept, push, pop;
    logic [1:0]   count;
    fetch_entry_t head, push_entry;
    logic         unused_target_bits;

    assign unused_target_bits = ^branch_target[1:0];

    assign imem_req   = (state_q == S_REQ) && (count < 2'(FIFO_DEPTH)) && !IF_Flush && !reset;
    assign imem_addr  = pc_q;
    assign accept     = imem_req && imem_ready;
    assign push       = (state_q == S_WAIT) && imem_valid && !IF_Flush;
    assign pop        = IFID_Write && IF_valid && !IF_Flush;
    assign push_entry = '{pcAdd4: fetch_pcadd4_q, inst: imem_rdata};

    always_ff @(posedge clk) begin
        rst_q <= reset;
        if (reset) begin
            pc_q           <= RESET_PC;
            state_q        <= S_REQ;
            fetch_pcadd4_q <= 32'h0;
        end else if (IF_Flush) begin
            pc_q <= {branch_target[31:2], 2'b00};
            // An in-flight fetch must still be retired, so wait for its return in S_DROP.
            case (state_q)
                S_WAIT, S_DROP: state_q <= imem_valid ? S_REQ : S_DROP;
                default:        state_q <= S_REQ;
            endcase
        end else begin
            case (state_q)
                S_REQ: if (accept) begin
                    fetch_pcadd4_q <= pc_q + 32'd4;
                    pc_q           <= pc_q + 32'd4;
                    state_q        <= S_WAIT;
                end
                S_WAIT:  if (imem_valid) state_q <= S_REQ;
                S_DROP:  if (imem_valid) state_q <= S_REQ;
                default: state_q <= S_REQ;
            endcase
        end
    end

    if_fetch_unit_fetch_buffer u_fetch_buffer (
        .clk        (clk),
        .reset      (reset),
        .push_i     (push),
        .push_dat_i (push_entry),
        .pop_i      (pop),
        .clear_i    (IF_Flush),
        .head_o     (head),
        .count_o    (count)
    );

    assign IF_valid  = (count != 2'd0);
    assign pcAdd4_IF = IF_valid ? head.pcAdd4 : 32'h0;
    assign inst_IF   = IF_valid ? head.inst   : NOP_INST;

    // A return just after reset belongs to a fetch abandoned by that reset and is legal.
    a_no_valid_in_req: assert property (@(posedge clk) disable iff (reset || rst_q)
        !(imem_valid && state_q == S_REQ));

endmodule
